// File: rtl/led_scan_pkg.sv
// Purpose : shared types and constants for the seven-segment scan multiplexer.
// Latency : n/a (package only).
// Backpressure: n/a; the display consumes every cycle.
package led_scan_pkg;

    typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Select one of the four digit patterns by index.
    function automatic logic [7:0] pick_digit(input logic [1:0] idx,
                                              input logic [7:0] d0,
                                              input logic [7:0] d1,
                                              input logic [7:0] d2,
                                              input logic [7:0] d3);
        logic [7:0] res;
        case (idx)
            2'd0:    res = d0;
            2'd1:    res = d1;
            2'd2:    res = d2;
            default: res = d3;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Purpose : N-bit free-running counter with synchronous clear and terminal count.
// Latency : count updates one cycle after clear/increment; tc is combinational on count.
// Backpressure: none; counts every cycle unless cleared.
// Ports: clk, clear (sync, wins over increment), tc (high when count is all ones).
module scan_prescaler #(
    parameter int N = 18
) (
    input  logic clk,
    input  logic clear,
    output logic tc
);

    localparam logic [N-1:0] ONE = 1;

    logic [N-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/led_scan_mux.sv
// Purpose : time-multiplexed scanner for a 4-digit seven-segment display with
//           guard blanking between digits.
// Latency : one register stage from in0..in3 (and blank_mask) to sseg/digit_en.
// Backpressure: none; free-running scan.
// Ports: clk, reset (sync, active-high), in0..in3 (active-low patterns {dp,g..a}),
//        blank_mask (only when LED_SCAN_BLANK_EN is defined), digit_sel, digit_en,
//        sseg (active-low), frame_tick (first SHOW cycle of digit 0).
// Optional feature macro: LED_SCAN_BLANK_EN adds per-digit blanking via blank_mask.
module led_scan_mux
    import led_scan_pkg::*;
#(
    parameter int N            = 18,
    parameter int GUARD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
`ifdef LED_SCAN_BLANK_EN
    input  logic [3:0] blank_mask,
`endif
    output logic [1:0] digit_sel,
    output logic       digit_en,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    // Guard counter needs at least one bit even when GUARD_CYCLES is 1.
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_ONE  = 1;

    scan_state_t   state;
    logic [GW-1:0] guard_cnt;
    logic [1:0]    next_idx;
    logic          guard_done;
    logic          show_tc;
    logic [7:0]    cur_pat;
    logic [7:0]    next_pat;
    logic          cur_blank;
    logic          next_blank;

    assign guard_done = (state == GUARD) && (guard_cnt == GUARD_LAST);

    // The prescaler runs freely; it only matters in SHOW, and it is zeroed on
    // the edge that enters SHOW so each slot lasts exactly 2^N cycles.
    scan_prescaler #(.N(N)) u_prescaler (
        .clk   (clk),
        .clear (reset | guard_done),
        .tc    (show_tc)
    );

    always_comb begin
        cur_pat  = pick_digit(digit_sel, in0, in1, in2, in3);
        next_pat = pick_digit(next_idx,  in0, in1, in2, in3);
`ifdef LED_SCAN_BLANK_EN
        cur_blank  = blank_mask[digit_sel];
        next_blank = blank_mask[next_idx];
`else
        cur_blank  = 1'b0;
        next_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= GUARD;
            guard_cnt  <= '0;
            next_idx   <= 2'd0;
            digit_sel  <= 2'd0;
            digit_en   <= 1'b0;
            sseg       <= SSEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                GUARD: begin
                    if (guard_done) begin
                        state      <= SHOW;
                        digit_sel  <= next_idx;
                        next_idx   <= next_idx + 2'd1;
                        digit_en   <= ~next_blank;
                        sseg       <= next_blank ? SSEG_OFF : next_pat;
                        frame_tick <= (next_idx == 2'd0);
                    end else begin
                        guard_cnt <= guard_cnt + GUARD_ONE;
                    end
                end
                SHOW: begin
                    if (show_tc) begin
                        // digit_en and sseg drop on the same edge; digit_sel
                        // holds until the next GUARD->SHOW.
                        state     <= GUARD;
                        guard_cnt <= '0;
                        digit_en  <= 1'b0;
                        sseg      <= SSEG_OFF;
                    end else begin
                        // Re-sample live inputs so pattern edits show next cycle.
                        digit_en <= ~cur_blank;
                        sseg     <= cur_blank ? SSEG_OFF : cur_pat;
                    end
                end
                default: begin
                    state <= GUARD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_mux.sv
// Purpose : self-checking bench for led_scan_mux with a slot-arithmetic reference model.
// Latency : model predicts registered outputs for each rising edge; checked on the falling edge.
// Backpressure: n/a.
module tb_led_scan_mux;

    localparam int N  = 2;
    localparam int G  = 2;
    localparam int S  = 1 << N;   // SHOW cycles per slot
    localparam int P  = S + G;    // cycles per slot

    logic       clk;
    logic       reset;
    logic [7:0] pat [4];
    logic [3:0] mask;
    logic [1:0] digit_sel;
    logic       digit_en;
    logic [7:0] sseg;
    logic       frame_tick;

    int tests;
    int fails;

    // Reference model state: edges since reset release (0 = reset edge).
    int         k;
    logic [1:0] exp_sel;
    logic       exp_en;
    logic [7:0] exp_sseg;
    logic       exp_tick;

    led_scan_mux #(.N(N), .GUARD_CYCLES(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0        (pat[0]),
        .in1        (pat[1]),
        .in2        (pat[2]),
        .in3        (pat[3]),
`ifdef LED_SCAN_BLANK_EN
        .blank_mask (mask),
`endif
        .digit_sel  (digit_sel),
        .digit_en   (digit_en),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", tag, k, got, exp);
        end
    endtask

    // Outputs after an edge follow from where that edge sits in the slot
    // sequence; SHOW sseg is whatever the selected input was at that edge.
    task automatic model_edge();
        int m, pos, d;
        logic blank;
        if (reset) k = 0;
        else       k = k + 1;
        exp_tick = 1'b0;
        exp_en   = 1'b0;
        exp_sseg = 8'hFF;
        if (k < G) begin
            exp_sel = 2'd0;
        end else begin
            m   = k - G;
            pos = m % P;
            d   = (m / P) % 4;
            exp_sel = d[1:0];
            if (pos < S) begin
`ifdef LED_SCAN_BLANK_EN
                blank = mask[d];
`else
                blank = 1'b0;
`endif
                exp_en   = !blank;
                exp_sseg = blank ? 8'hFF : pat[d];
                exp_tick = (pos == 0) && (d == 0);
            end
        end
    endtask

    task automatic check_outputs();
        check("digit_sel",  {30'd0, digit_sel}, {30'd0, exp_sel});
        check("digit_en",   {31'd0, digit_en},  {31'd0, exp_en});
        check("sseg",       {24'd0, sseg},      {24'd0, exp_sseg});
        check("frame_tick", {31'd0, frame_tick},{31'd0, exp_tick});
    endtask

    initial begin
        bit did_edit;
        bit did_reset;
        tests = 0;
        fails = 0;
        k = 0;
        did_edit  = 1'b0;
        did_reset = 1'b0;
        reset  = 1'b1;
        pat[0] = 8'hC0;
        pat[1] = 8'hF9;
        pat[2] = 8'hA4;
        pat[3] = 8'hB0;
        mask   = 4'b0000;

        // Reset held for a few edges: outputs must sit at reset values.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b0;

        // Directed phase: fixed patterns, a mid-slot edit of in1 and a reset
        // during digit 2 SHOW, followed by a clean frame.
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            reset = 1'b0;
            if (!did_edit && k == G + P + 1) begin
                pat[1]   = 8'h99;   // second SHOW cycle of digit 1
                did_edit = 1'b1;
            end else if (!did_reset && k == G + 2 * P + 1) begin
                reset     = 1'b1;   // inside digit 2 SHOW
                did_reset = 1'b1;
            end
        end

`ifdef LED_SCAN_BLANK_EN
        // Blank digit 2 for a couple of frames; frame timing must not move.
        mask = 4'b0100;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
`endif

        // Randomized phase: pattern edits, occasional resets and mask changes.
        for (int c = 0; c < 900; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0)
                pat[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 39) == 0)
                mask = 4'($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_scan_mux.md
# led_scan_mux

Time-multiplexed scanner for a four-digit seven-segment display. It sits directly upstream of the 2-to-4 binary decoder. Each digit slot drives the decoder's `binary_in` from `digit_sel` and its `en` from `digit_en`, and presents the matching segment pattern on `sseg`. A guard interval, with all segments off and the decoder disabled, separates successive digits to suppress ghosting.

## Interface
- `N`, 18: prescaler width; SHOW phase lasts 2^N cycles; N ≥ 1
- `GUARD_CYCLES`, 4: blanking cycles between digits; ≥ 1
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in0`..`in3`  in  8 each  active-low segment patterns, {dp,g..a}, for digits 0..3
- `blank_mask`  in  4  per-digit blank request (only with `LED_SCAN_BLANK_EN`)
- `digit_sel`  out  2  digit index; feeds decoder `binary_in`
- `digit_en`  out  1  decoder enable; high only in SHOW
- `sseg`  out  8  active-low segment drive
- `frame_tick`  out  1  one-cycle pulse on the first SHOW cycle of digit 0

## Operation
- Reset values: `digit_sel`=0, `digit_en`=0, `sseg`=8'hFF, `frame_tick`=0. Internal state: state=GUARD, guard count=0, prescaler=0, next index=0.
- Two-state FSM:
  - GUARD: `digit_en`=0 and `sseg`=8'hFF. The guard counter counts 0..GUARD_CYCLES-1. On the edge where the count equals GUARD_CYCLES-1:
    - state goes to SHOW
    - `digit_sel` loads the next index
    - the next index increments mod 4 (3→0)
    - `digit_en` rises
    - `sseg` loads in[next index]
    - the prescaler clears
  - SHOW: the prescaler counts 0..2^N-1. On terminal count, state goes to GUARD, the guard counter clears, `digit_en` falls and `sseg` goes to 8'hFF on that same edge.
- While in SHOW, `sseg` re-samples in[digit_sel] every cycle, so a change on an input appears one cycle later.
- `digit_sel` holds its value through the following GUARD phase and changes only on GUARD→SHOW.
- Digit order is 0,1,2,3,0,… After reset the first digit shown is 0.
- `frame_tick` pulses high for exactly one cycle, coincident with the first SHOW cycle of digit 0. This includes the first SHOW after reset.
- Reset asserted mid-SHOW or mid-GUARD: on the next edge every register returns to its reset value and the scan restarts from GUARD with digit 0.
- Inputs are not registered before use. Their only latency is the single `sseg` output register.

## Timing
- All outputs are registered and free of glitches.
- Per-digit period: 2^N + GUARD_CYCLES cycles. Frame period: 4·(2^N + GUARD_CYCLES).
- Counting edge 1 as the first rising edge with reset low, `digit_en` first goes high after edge GUARD_CYCLES.
- `digit_en` and `sseg` change on the same edge, so the decoder never sees a new index while segments are lit.

## Configuration
- Macro: `LED_SCAN_BLANK_EN`.
- Defined:
  - The `blank_mask` port exists.
  - In a SHOW slot whose digit has its mask bit set, `digit_en` stays 0 and `sseg` stays 8'hFF.
  - The mask is evaluated every cycle, so it takes effect mid-slot with one cycle of latency.
  - Slot timing, `digit_sel` sequencing and `frame_tick` are unchanged.
- Undefined: the port is absent and no digit is ever blanked.

## Structure
- Package `led_scan_pkg` contains:
  - `typedef enum logic {GUARD, SHOW} scan_state_t`
  - `localparam NUM_DIGITS = 4`
  - `localparam logic [7:0] SSEG_OFF = 8'hFF`
- One sub-module, `scan_prescaler`: a parameterized N-bit free-running counter with synchronous clear and a terminal-count output. It is instantiated once for the SHOW phase.

## Test plan
Bench settings: N=2, GUARD_CYCLES=2, in0..in3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0.
- Release reset → `digit_en`=0 and `sseg`=8'hFF for 2 cycles. Then `digit_en`=1, `digit_sel`=0, `sseg`=8'hC0 and `frame_tick`=1 for 1 cycle. The SHOW slot lasts 4 cycles.
- Run 24 cycles → `digit_sel` steps 0,1,2,3 with `sseg` C0,F9,A4,B0. Every slot is 4 cycles SHOW + 2 cycles GUARD. `frame_tick` repeats every 24 cycles.
- Change in1 to 8'h99 in the 2nd SHOW cycle of digit 1 → `sseg`=8'h99 from the 3rd SHOW cycle.
- Assert reset during digit 2 SHOW → next edge gives `digit_en`=0, `sseg`=8'hFF, `digit_sel`=0. After release the scan restarts at digit 0 with a `frame_tick`.
- With `LED_SCAN_BLANK_EN`, `blank_mask`=4'b0100 → the digit-2 slot shows `digit_en`=0 and `sseg`=8'hFF while `digit_sel`=2. The frame is still 24 cycles.
- Check every GUARD cycle → `digit_en`=0 and `sseg`=8'hFF. `digit_sel` never changes while `digit_en`=1.
